// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: parses a counted header plus 3-byte words and
// writes each assembled word to instruction memory while holding the CPU in reset.
module instruction_loader #(
    parameter int INSTR_LEN = 19,
    parameter int ADDR_LEN  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 im_we,
    output logic [ADDR_LEN-1:0]  im_addr,
    output logic [INSTR_LEN-1:0] im_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_B0, S_B1, S_B2, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_LEN-1:0]    cnt_q, cnt_d;
    logic [11:0]            count_q, count_d;
    logic [INSTR_LEN-1:0]   word_q, word_d;
    logic [ADDR_LEN-1:0]    cnt_inc;
    logic                   xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    assign in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
    assign xfer     = in_valid & in_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (xfer) begin
                    if (in_data[7:4] != 4'h0) begin
                        state_d = S_ERROR;
                    end else begin
                        count_d[11:8] = in_data[3:0];
                        state_d       = S_HDR_LO;
                    end
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = in_data;
                    if ({count_q[11:8], in_data} == 12'h000) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (xfer) begin
                    if (in_data[7:3] != 5'h00) begin
                        state_d = S_ERROR;
                    end else begin
                        word_d  = INSTR_LEN'(in_data[2:0]);
                        state_d = S_B1;
                    end
                end
            end
            S_B1: begin
                if (xfer) begin
                    word_d  = {word_q[INSTR_LEN-9:0], in_data};
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    word_d  = {word_q[INSTR_LEN-9:0], in_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Header count fits in 12 bits, so the address counter never wraps.
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == ADDR_LEN'(count_q)) ? S_DONE : S_B0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign im_we    = (state_q == S_WRITE);
    assign im_addr  = cnt_q;
    assign im_wdata = word_q;
    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as the
// stream is driven and checked when im_we pulses.
module tb_instruction_loader;

    localparam int IL = 19;
    localparam int AL = 12;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AL-1:0] a;
        logic [IL-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, im_we, cpu_hold, done, error;
    logic [AL-1:0] im_addr;
    logic [IL-1:0] im_wdata;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  writes = 0;
    int  xfers = 0;
    wr_t exp_q[$];

    instruction_loader #(.INSTR_LEN(IL), .ADDR_LEN(AL)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (in_valid && in_ready) xfers++;
        if (im_we) begin
            writes++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0h data=%05h, expected no write", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                if (im_addr !== e.a || im_wdata !== e.d) begin
                    miscompares++;
                    $display("FAIL write_data: got addr=%0h data=%05h, expected addr=%0h data=%05h",
                             im_addr, im_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send(input bq_t b, input bit gap);
        bit ok;
        foreach (b[i]) begin
            in_valid = 1'b1;
            in_data  = b[i];
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL handshake_timeout: byte %0d (%02h) got in_ready=0, expected 1", i, b[i]);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            if (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(output int lat);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        lat = cyc - start_cyc + 1;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: got done=0, expected 1");
            lat = -1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready, im_we, done, error, cpu_hold} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy/we/done/err/hold=%b, expected 00001",
                     {in_ready, im_we, done, error, cpu_hold});
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, done, cpu_hold} !== 3'b001) begin
                miscompares++;
                $display("FAIL idle_after_reset: got rdy/done/hold=%b, expected 001", {in_ready, done, cpu_hold});
            end
        end
    endtask

    task automatic test_two_words(input bit gap, input int exp_lat);
        int lat, w0, x0;
        bq_t s;
        s = '{8'h00, 8'h02, 8'h07, 8'hAB, 8'hCD, 8'h01, 8'h23, 8'h45};
        exp_q.push_back({12'h000, 19'h7ABCD});
        exp_q.push_back({12'h001, 19'h12345});
        w0 = writes; x0 = xfers;
        pulse_start();
        send(s, gap);
        wait_done(lat);
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL two_word_latency gap=%0d: got cycle %0d, expected %0d", gap, lat, exp_lat);
        end
        vectors++;
        if (cpu_hold !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL two_word_flags: got hold=%b err=%b, expected 0 0", cpu_hold, error);
        end
        vectors++;
        if (writes - w0 != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL two_word_count: got %0d writes (%0d pending), expected 2 (0)", writes - w0, exp_q.size());
        end
        vectors++;
        if (xfers - x0 != 8) begin
            miscompares++;
            $display("FAIL byte_consumption: got %0d transfers, expected 8", xfers - x0);
        end
    endtask

    task automatic test_empty();
        int lat, w0;
        bq_t s;
        s = '{8'h00, 8'h00};
        w0 = writes;
        pulse_start();
        send(s, 1'b0);
        wait_done(lat);
        vectors++;
        if (lat != 3 || cpu_hold !== 1'b0 || writes != w0) begin
            miscompares++;
            $display("FAIL empty_load: got cycle=%0d hold=%b writes=%0d, expected 3 0 0", lat, cpu_hold, writes - w0);
        end
    endtask

    task automatic test_error_hdr();
        int lat, w0;
        bq_t s;
        s = '{8'h10};
        w0 = writes;
        pulse_start();
        send(s, 1'b0);
        @(negedge clk);
        vectors++;
        if ({error, cpu_hold, in_ready, done} !== 4'b1100 || writes != w0) begin
            miscompares++;
            $display("FAIL hdr_error: got err/hold/rdy/done=%b writes=%0d, expected 1100 0",
                     {error, cpu_hold, in_ready, done}, writes - w0);
        end
        s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h2A};
        exp_q.push_back({12'h000, 19'h0002A});
        pulse_start();
        send(s, 1'b0);
        wait_done(lat);
        vectors++;
        if (error !== 1'b0 || done !== 1'b1 || exp_q.size() != 0 || writes - w0 != 1) begin
            miscompares++;
            $display("FAIL error_recovery: got err=%b done=%b writes=%0d, expected 0 1 1", error, done, writes - w0);
        end
    endtask

    task automatic test_error_b0();
        int w0;
        bq_t s;
        s = '{8'h00, 8'h01, 8'h08};
        w0 = writes;
        pulse_start();
        send(s, 1'b0);
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({error, in_ready, cpu_hold} !== 3'b101 || writes != w0) begin
                miscompares++;
                $display("FAIL b0_error: got err/rdy/hold=%b writes=%0d, expected 101 0",
                         {error, in_ready, cpu_hold}, writes - w0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, w0;
        bq_t s;
        logic [IL-1:0] d;
        s = '{8'h00, 8'h03};
        for (int i = 0; i < 3; i++) begin
            d = IL'($urandom_range(0, 19'h7FFFF));
            s.push_back({5'b0, d[18:16]});
            s.push_back(d[15:8]);
            s.push_back(d[7:0]);
            exp_q.push_back({AL'(i), d});
        end
        w0 = writes;
        pulse_start();
        vectors++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_hold: got hold=%b done=%b, expected 1 0", cpu_hold, done);
        end
        send(s, 1'b0);
        wait_done(lat);
        vectors++;
        if (lat != 15 || writes - w0 != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL three_words: got cycle=%0d writes=%0d, expected 15 3", lat, writes - w0);
        end
    endtask

    task automatic test_reset_midload();
        int w0;
        bq_t s;
        s = '{8'h00, 8'h02, 8'h07, 8'hAB, 8'hCD, 8'h01};
        exp_q.push_back({12'h000, 19'h7ABCD});
        w0 = writes;
        pulse_start();
        send(s, 1'b0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, cpu_hold, done, error, im_we} !== 5'b01000) begin
            miscompares++;
            $display("FAIL async_reset: got rdy/hold/done/err/we=%b, expected 01000",
                     {in_ready, cpu_hold, done, error, im_we});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, cpu_hold, done} !== 3'b010) begin
                miscompares++;
                $display("FAIL idle_after_abort: got rdy/hold/done=%b, expected 010", {in_ready, cpu_hold, done});
            end
        end
        vectors++;
        if (writes - w0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_writes: got %0d writes, expected 1", writes - w0);
        end
    endtask

    task automatic test_start_ignored();
        int lat, w0;
        bq_t s;
        s = '{8'h00};
        exp_q.push_back({12'h000, 19'h00033});
        w0 = writes;
        pulse_start();
        send(s, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s = '{8'h01, 8'h00, 8'h00, 8'h33};
        send(s, 1'b0);
        wait_done(lat);
        vectors++;
        if (lat != 9 || writes - w0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL start_in_hdr_lo: got cycle=%0d writes=%0d, expected 9 1", lat, writes - w0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_two_words(1'b0, 11);
        test_empty();
        test_error_hdr();
        test_error_b0();
        test_two_words(1'b1, 17);
        test_back_to_back();
        test_reset_midload();
        test_start_ignored();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
